// File: rtl/pixel_mixer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_mixer
// Function : Output-side consumer of the pixel FIFO. Prefetches words into a
//            2-entry holding buffer, aligns to frame start, blends the OSD
//            over the video through a 16-entry CLUT and emits YUV pixels,
//            substituting blanks on underrun or while hunting for sync.
// Revision : 1.0  initial release
// ============================================================================
module pixel_mixer #(
  parameter logic [7:0] BLANK_Y = 8'd16,
  parameter logic [7:0] BLANK_C = 8'd128,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  output logic             pixel_rd_en,
  input  logic             pixel_rd_empty,
  input  logic             pixel_rd_valid,
  input  logic [7:0]       y_in,
  input  logic [7:0]       u_in,
  input  logic [7:0]       v_in,
  input  logic [7:0]       osd_in,
  input  logic [2:0]       position_in,
  input  logic             osd_enable,
  input  logic             clut_wr_en,
  input  logic [3:0]       clut_wr_addr,
  input  logic [23:0]      clut_wr_dat,
  input  logic             frame_req,
  input  logic             pixel_req,
  output logic [7:0]       y_out,
  output logic [7:0]       u_out,
  output logic [7:0]       v_out,
  output logic             pixel_out_valid,
  output logic             pixel_out_blank,
  output logic [CNT_W-1:0] underrun_count,
  output logic             sync_lost
);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Word layout: {y[34:27], u[26:19], v[18:11], osd[10:3], pos[2:0]}
  logic [34:0] buf0, buf1;
  logic [1:0]  occ;
  logic        in_flight;
  logic [34:0] rd_word;
  logic [2:0]  head_pos;
  logic        head_ok;

  state_t state, state_nx;
  logic   pop, emit_blank, count_inc;

  logic [23:0] clut [16];

  logic        s1_valid, s1_blank;
  logic [7:0]  s1_y, s1_u, s1_v;
  logic [4:0]  s1_w;
  logic [23:0] s1_clut;
  logic [4:0]  head_w;

  logic        out_valid_r;

  assign rd_word  = {y_in, u_in, v_in, osd_in, position_in};
  assign head_ok  = (occ != 2'd0);
  // Undefined position codes 5..7 behave like mid-line pixels.
  assign head_pos = (buf0[2:0] > 3'd4) ? 3'd0 : buf0[2:0];
  assign head_w   = !osd_enable ? 5'd0 :
                    (buf0[10:7] == 4'hF) ? 5'd16 : {1'b0, buf0[10:7]};

  // Keep buffer plus outstanding read within the two holding slots.
  assign pixel_rd_en = clk_en & ~pixel_rd_empty &
                       (({1'b0, occ} + {2'b00, in_flight}) < 3'd2);

  assign sync_lost       = (state != ST_RUN);
  assign pixel_out_valid = out_valid_r & clk_en;

  function automatic logic [7:0] blend(input logic [7:0] p, input logic [7:0] c,
                                       input logic [4:0] w);
    logic [12:0] acc;
    acc = 13'(p) * 13'(5'd16 - w) + 13'(c) * 13'(w) + 13'd8;
    return 8'(acc >> 4);
  endfunction

  // Sync FSM decisions: which head to consume and whether to blank.
  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    emit_blank = 1'b1;
    count_inc  = 1'b0;
    case (state)
      ST_HUNT: begin
        if (head_ok) begin
          if (head_pos == 3'd2) state_nx = ST_WAIT;
          else                  pop      = 1'b1;
        end
      end
      ST_WAIT: begin
        if (pixel_req && frame_req && head_ok) begin
          pop        = 1'b1;
          emit_blank = 1'b0;
          state_nx   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pixel_req) begin
          if (head_ok) begin
            pop        = 1'b1;
            emit_blank = 1'b0;
            if ((head_pos == 3'd2) != frame_req) state_nx = ST_HUNT;
          end else begin
            count_inc = 1'b1;
          end
        end
      end
      default: state_nx = ST_HUNT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         state <= ST_HUNT;
    else if (clk_en) state <= state_nx;
  end

  // Holding buffer: prefetch landing and head consumption may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0      <= '0;
      buf1      <= '0;
      occ       <= 2'd0;
      in_flight <= 1'b0;
    end else if (clk_en) begin
      in_flight <= pixel_rd_en | (in_flight & ~pixel_rd_valid);
      case ({pop, pixel_rd_valid})
        2'b11: begin
          if (occ == 2'd2) begin
            buf0 <= buf1;
            buf1 <= rd_word;
          end else begin
            buf0 <= rd_word;
          end
        end
        2'b10: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b01: begin
          if (occ == 2'd0) buf0 <= rd_word;
          else             buf1 <= rd_word;
          if (occ != 2'd2) occ <= occ + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // CLUT storage; a same-cycle read sees the previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) clut[i] <= '0;
    end else if (clk_en && clut_wr_en) begin
      clut[clut_wr_addr] <= clut_wr_dat;
    end
  end

  // Stage 1: capture popped pixel (or blank), weight and CLUT colour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_blank <= 1'b0;
      s1_y     <= '0;
      s1_u     <= '0;
      s1_v     <= '0;
      s1_w     <= '0;
      s1_clut  <= '0;
    end else if (clk_en) begin
      s1_valid <= pixel_req;
      s1_blank <= emit_blank;
      s1_clut  <= clut[buf0[6:3]];
      if (emit_blank) begin
        s1_y <= BLANK_Y;
        s1_u <= BLANK_C;
        s1_v <= BLANK_C;
        s1_w <= 5'd0;
      end else begin
        s1_y <= buf0[34:27];
        s1_u <= buf0[26:19];
        s1_v <= buf0[18:11];
        s1_w <= head_w;
      end
    end
  end

  // Stage 2: blend and register the output pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r     <= 1'b0;
      pixel_out_blank <= 1'b0;
      y_out           <= '0;
      u_out           <= '0;
      v_out           <= '0;
    end else if (clk_en) begin
      out_valid_r     <= s1_valid;
      pixel_out_blank <= s1_valid & s1_blank;
      y_out           <= blend(s1_y, s1_clut[23:16], s1_w);
      u_out           <= blend(s1_u, s1_clut[15:8],  s1_w);
      v_out           <= blend(s1_v, s1_clut[7:0],   s1_w);
    end
  end

  // Saturating count of blanks emitted while locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) underrun_count <= '0;
    else if (clk_en && count_inc && !(&underrun_count))
      underrun_count <= underrun_count + CNT_W'(1);
  end

endmodule
`default_nettype wire
